// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage
// ----------------------------------------------------------------------------
// IF stage of the 5-stage pipelined MIPS core. It owns the program counter
// and the IF/ID pipeline register. It drives the instruction-memory address
// and captures the word that comes back in the same cycle. It honours the
// hazard-unit stall and takes redirects from beq/bne (resolved in EX) and
// from j/jal (resolved in ID). On a redirect the wrong-path word that would
// have entered IF/ID is replaced by a NOP bubble.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, two saturating performance counters are added:
//   flush_count (redirects applied) and stall_count (stalled edges that had
//   no redirect). When undefined, those ports and their logic do not exist.
//
// Ports
//   clk            in   1      rising-edge clock
//   reset          in   1      synchronous, active-high reset
//   imem_addr      out  32     instruction-memory byte address (= PC)
//   imem_data      in   32     instruction word for imem_addr (same cycle)
//   stall          in   1      hold PC and IF/ID
//   branch_taken   in   1      beq/bne in EX resolved taken
//   branch_target  in   32     branch destination from EX
//   jump           in   1      j/jal decoded in ID
//   jump_target    in   32     jump destination from ID
//   if_id_instr    out  32     registered instruction to ID
//   if_id_pc4      out  32     registered PC+4 of that instruction
//   if_id_valid    out  1      1 = if_id_instr is a real instruction
//   flush_count    out  CNT_W  redirects applied   (FETCH_PERF_CNT_EN)
//   stall_count    out  CNT_W  stalled edges       (FETCH_PERF_CNT_EN)
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic [31:0]       imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              jump,
    input  logic [31:0]       jump_target,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc4,
    output logic              if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  flush_count,
    output logic [CNT_W-1:0]  stall_count
`endif
);

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Word-align a redirect target before it reaches the PC.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        word_align = {a[31:2], 2'b00};
    endfunction

    logic [31:0] r_pc;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc4;
    logic        r_if_id_valid;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc4;

    // Branch (older, in EX) wins over jump (younger, in ID, itself on the
    // wrong path when the branch is taken). Any redirect overrides stall.
    always_comb begin
        w_redirect = branch_taken | jump;
        w_target   = branch_taken ? word_align(branch_target)
                                  : word_align(jump_target);
        w_pc4      = r_pc + 32'd4;   // wraps mod 2^32 by construction
    end

    // ---- IF -> IF/ID boundary ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc4   <= 32'h0000_0000;
            r_if_id_valid <= 1'b0;
        end else if (w_redirect) begin
            r_pc          <= w_target;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc4   <= 32'h0000_0000;
            r_if_id_valid <= 1'b0;
        end else if (!stall) begin
            r_pc          <= w_pc4;
            r_if_id_instr <= imem_data;
            r_if_id_pc4   <= w_pc4;
            r_if_id_valid <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] r_flush_count;
    logic [CNT_W-1:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_redirect) begin
                r_flush_count <= sat_inc(r_flush_count);
            end
            // A stall overridden by a redirect is not a stalled edge.
            if (stall && !w_redirect) begin
                r_stall_count <= sat_inc(r_stall_count);
            end
        end
    end

    assign flush_count = r_flush_count;
    assign stall_count = r_stall_count;
`endif

    assign imem_addr   = r_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_pc4   = r_if_id_pc4;
    assign if_id_valid = r_if_id_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Instruction memory returns
// 32'h2001_0000 | addr[15:0] (an addi whose immediate is its own address),
// so every fetched word is distinguishable by hand.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] flush_count;
    logic [31:0] stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_data = 32'h2001_0000 | {16'h0000, imem_addr[15:0]};

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .flush_count   (flush_count),
        .stall_count   (stall_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0;
        step();
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp %h", imem_addr, 32'h0); end
        n_checks++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp %h", if_id_instr, 32'h0); end
        n_checks++; if (if_id_pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 got %h exp %h", if_id_pc4, 32'h0); end
        n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
`ifdef FETCH_PERF_CNT_EN
        n_checks++; if (flush_count !== 32'd0 || stall_count !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", flush_count, stall_count); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_advance();
        // edge 1: fetch 0x0
        step();
        n_checks++; if (if_id_instr !== 32'h2001_0000) begin n_fail++; $display("FAIL adv1_instr got %h exp %h", if_id_instr, 32'h2001_0000); end
        n_checks++; if (if_id_pc4 !== 32'h4 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL adv1_pc4_valid got %h/%b exp 4/1", if_id_pc4, if_id_valid); end
        n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL adv1_pc got %h exp 4", imem_addr); end
        // edge 2: fetch 0x4
        step();
        n_checks++; if (if_id_instr !== 32'h2001_0004) begin n_fail++; $display("FAIL adv2_instr got %h exp %h", if_id_instr, 32'h2001_0004); end
        n_checks++; if (if_id_pc4 !== 32'h8 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL adv2_pc4_pc got %h/%h exp 8/8", if_id_pc4, imem_addr); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (imem_addr !== 32'h8 || if_id_instr !== 32'h2001_0004 || if_id_pc4 !== 32'h8 || if_id_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold%0d got pc %h instr %h pc4 %h v %b exp 8 20010004 8 1", i, imem_addr, if_id_instr, if_id_pc4, if_id_valid);
            end
        end
        stall = 1'b0;
        step();
        n_checks++; if (if_id_instr !== 32'h2001_0008 || if_id_pc4 !== 32'hC || imem_addr !== 32'hC) begin n_fail++; $display("FAIL stall_release got instr %h pc4 %h pc %h exp 20010008 c c", if_id_instr, if_id_pc4, imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        n_checks++; if (stall_count !== 32'd3) begin n_fail++; $display("FAIL stall_count got %0d exp 3", stall_count); end
`endif
        step(); // pc -> 0x10
        n_checks++; if (imem_addr !== 32'h10 || if_id_instr !== 32'h2001_000C) begin n_fail++; $display("FAIL adv_to_10 got pc %h instr %h exp 10 2001000c", imem_addr, if_id_instr); end
    endtask

    task automatic test_branch();
        branch_taken = 1'b1; branch_target = 32'h40;
        step();
        branch_taken = 1'b0;
        n_checks++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL br_pc got %h exp 40", imem_addr); end
        n_checks++; if (if_id_instr !== 32'h0 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL br_flush got %h/%b exp 0/0", if_id_instr, if_id_valid); end
        step();
        n_checks++; if (if_id_instr !== 32'h2001_0040 || if_id_pc4 !== 32'h44 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL br_next got %h/%h/%b exp 20010040/44/1", if_id_instr, if_id_pc4, if_id_valid); end
`ifdef FETCH_PERF_CNT_EN
        n_checks++; if (flush_count !== 32'd1) begin n_fail++; $display("FAIL br_flush_count got %0d exp 1", flush_count); end
`endif
    endtask

    task automatic test_redirect_priority();
        branch_taken = 1'b1; branch_target = 32'h40;
        jump = 1'b1; jump_target = 32'h80; stall = 1'b1;
        step();
        branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;
        n_checks++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL prio_pc got %h exp 40", imem_addr); end
        n_checks++; if (if_id_instr !== 32'h0 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL prio_flush got %h/%b exp 0/0", if_id_instr, if_id_valid); end
`ifdef FETCH_PERF_CNT_EN
        n_checks++; if (flush_count !== 32'd2 || stall_count !== 32'd3) begin n_fail++; $display("FAIL prio_counts got %0d/%0d exp 2/3", flush_count, stall_count); end
`endif
        // jump alone, with stall: jump wins over stall
        jump = 1'b1; jump_target = 32'h80; stall = 1'b1;
        step();
        jump = 1'b0; stall = 1'b0;
        n_checks++; if (imem_addr !== 32'h80 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL jump_pc got %h/%b exp 80/0", imem_addr, if_id_valid); end
    endtask

    task automatic test_wrap_align();
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        step();
        jump = 1'b0;
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_load got %h exp fffffffc", imem_addr); end
        step();
        n_checks++; if (imem_addr !== 32'h0 || if_id_pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got %h/%h exp 0/0", imem_addr, if_id_pc4); end
        n_checks++; if (if_id_instr !== 32'h2001_FFFC || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_instr got %h/%b exp 2001fffc/1", if_id_instr, if_id_valid); end
        branch_taken = 1'b1; branch_target = 32'h43;
        step();
        branch_taken = 1'b0;
        n_checks++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL align_pc got %h exp 40", imem_addr); end
    endtask

    task automatic test_reset_mid_stall();
        jump = 1'b1; jump_target = 32'h20;
        step();
        jump = 1'b0; stall = 1'b1;
        step();
        n_checks++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL pre_reset_pc got %h exp 20", imem_addr); end
        reset = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        step();
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        n_checks++; if (imem_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin n_fail++; $display("FAIL mid_reset got pc %h v %b instr %h exp 0 0 0", imem_addr, if_id_valid, if_id_instr); end
`ifdef FETCH_PERF_CNT_EN
        n_checks++; if (flush_count !== 32'd0 || stall_count !== 32'd0) begin n_fail++; $display("FAIL mid_reset_cnt got %0d/%0d exp 0/0", flush_count, stall_count); end
`endif
        step();
        n_checks++; if (if_id_instr !== 32'h2001_0000 || if_id_pc4 !== 32'h4 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL post_reset got %h/%h/%h exp 20010000/4/4", if_id_instr, if_id_pc4, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_advance();
        test_stall();
        test_branch();
        test_redirect_priority();
        test_wrap_align();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
